mmr_scrub_ctrl: RTL
===================

# mmr_scrub_ctrl

Round-robin scrub controller for a bank of triple-modular-redundant (TMR) configuration registers. It scans the per-register `mismatch` flags, issues a one-cycle refresh (re-vote/rewrite) pulse to a register whose replicas disagree, and waits a settle window. It then reports the event to the slow-control readout over a valid/ready handshake. It sits beside the MMR register bank and is the only source of refresh requests to it.

## Interface

Parameters:
- `NUM_REG`, 8: number of monitored registers; ≥2.
- `CNT_W`, 16: width of the saturating error counter.
- `SETTLE_CYC`, 3: cycles waited after a refresh before re-sampling the mismatch flag; ≥1.

Ports:
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  reset; synchronous and active-low.
- `enable_i`  in  1  scrubbing enable (level).
- `mismatch_i`  in  NUM_REG  per-register replica-mismatch flags, synchronous to `clk_i`.
- `clear_count_i`  in  1  single-cycle clear of `err_count_o`.
- `refresh_o`  out  NUM_REG  one-hot, one-cycle refresh pulse.
- `evt_valid_o`  out  1  event available.
- `evt_ready_i`  in  1  readout accepts event.
- `evt_idx_o`  out  $clog2(NUM_REG)  index of refreshed register.
- `evt_persist_o`  out  1  mismatch still present after settle window.
- `err_count_o`  out  CNT_W  refreshes issued since reset or clear; saturating.
- `busy_o`  out  1  FSM not in IDLE.

## Operation

- States: IDLE, SCAN, REFRESH, SETTLE, REPORT. `idx` register is the scan pointer, width `$clog2(NUM_REG)`.
- IDLE: `idx`=0. `enable_i`=1 → SCAN.
- SCAN: one index per cycle.
  - `enable_i`=0 → IDLE; `idx` returns to 0.
  - `mismatch_i[idx]`=1 → REFRESH; `idx` is held.
  - Otherwise `idx` increments, wrapping from NUM_REG-1 to 0.
- REFRESH: exactly one cycle.
  - `refresh_o[idx]`=1; all other bits 0.
  - `err_count_o` increments, saturating at 2^CNT_W-1.
  - → SETTLE. The settle counter loads SETTLE_CYC-1.
- SETTLE: counts down to 0. In the last SETTLE cycle, `mismatch_i[idx]` is captured into `evt_persist_o`. → REPORT.
- REPORT:
  - `evt_valid_o`=1. `evt_idx_o` and `evt_persist_o` are stable until the handshake.
  - On `evt_valid_o & evt_ready_i`: `idx` increments with wrap. Next state is SCAN if `enable_i`=1, else IDLE (`idx`=0).
- `enable_i` deasserted during REFRESH, SETTLE or REPORT does not abort. The event completes through handshake, then IDLE.
- `clear_count_i`: `err_count_o`←0 next cycle. If it coincides with a REFRESH increment, clear wins (result 0).
- A register with a persistent mismatch is refreshed again on every scan pass. No blacklisting.
- `busy_o` = (state ≠ IDLE).
- `evt_idx_o` and `evt_persist_o` are 0 outside REPORT.

## Timing

- Reset (`rst_n_i`=0 at a clock edge):
  - State IDLE; `idx`=0.
  - `refresh_o`=0, `evt_valid_o`=0, `evt_idx_o`=0, `evt_persist_o`=0, `err_count_o`=0, `busy_o`=0.
  - Reset mid-event drops the event without reporting it. A `refresh_o` pulse in flight is deasserted the next cycle.
- All outputs are registered.
- Event sequence, with `mismatch_i[k]` sampled high in SCAN at cycle t:
  - `refresh_o[k]` high during cycle t+1.
  - `err_count_o` updated at t+2.
  - SETTLE occupies t+2 … t+1+SETTLE_CYC.
  - `evt_valid_o` rises at t+2+SETTLE_CYC.
- With `evt_ready_i` held at 1, REPORT lasts one cycle and SCAN resumes at index k+1 on the following cycle. Per-event cost is SETTLE_CYC+3 cycles.
- Clean pass: NUM_REG cycles per full scan.
- From IDLE: `enable_i` high at cycle t → SCAN at t+1, index 0 examined in cycle t+1.

## Test plan

- **Reset:** hold `rst_n_i`=0 for 3 cycles with `enable_i`=1 and `mismatch_i`=all-ones → all outputs 0 and `busy_o`=0. First `refresh_o`=8'b0000_0001 appears 2 cycles after reset release.
- **Single event (NUM_REG=8, SETTLE_CYC=3):** `mismatch_i[5]` pulses high for the cycle the controller reaches index 5, `evt_ready_i`=1 → one `refresh_o`=8'b0010_0000 pulse. Then `evt_valid_o` for 1 cycle with `evt_idx_o`=5 and `evt_persist_o`=0. `err_count_o`=1; next index examined is 6.
- **Persistent fault with backpressure:** `mismatch_i[7]` stuck high, `evt_ready_i` low for 10 cycles → `evt_valid_o`, `evt_idx_o`=7 and `evt_persist_o`=1 held stable for all 10 cycles. After acceptance, scan wraps to index 0. Index 7 is refreshed again on every pass and the count increments once per pass.
- **Enable drop:** deassert `enable_i` during SETTLE → event still reported, then IDLE with `busy_o`=0. Deassert `enable_i` during SCAN at index 3 → IDLE next cycle; re-enable restarts at index 0.
- **Counter:** with CNT_W=4, force 20 events → `err_count_o` saturates at 15. `clear_count_i` asserted in the same cycle as a REFRESH → `err_count_o`=0, not 1.
- **Mid-event reset:** assert `rst_n_i`=0 during REPORT → `evt_valid_o`=0 next cycle. No event is reported after reset release until a new mismatch is seen.

Source files
------------

// File: rtl/mmr_scrub_ctrl.sv
// Round-robin scrub controller for a TMR configuration register bank: finds a
// mismatching register, pulses its refresh, waits a settle window and reports the outcome.
module mmr_scrub_ctrl #(
  parameter int NUM_REG    = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       enable_i,
  input  logic [NUM_REG-1:0]         mismatch_i,
  input  logic                       clear_count_i,
  output logic [NUM_REG-1:0]         refresh_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(NUM_REG)-1:0] evt_idx_o,
  output logic                       evt_persist_o,
  output logic [CNT_W-1:0]           err_count_o,
  output logic                       busy_o
);

  localparam int IDX_W = $clog2(NUM_REG);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_REFRESH,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n, idx_inc;
  logic [SET_W-1:0]   settle_q, settle_n;
  logic               persist_n;
  logic [NUM_REG-1:0] refresh_n;
  logic [NUM_REG-1:0] one_hot_base;
  logic               handshake;

  assign one_hot_base = {{(NUM_REG-1){1'b0}}, 1'b1};
  assign idx_inc      = (idx_q == IDX_W'(NUM_REG-1)) ? '0 : idx_q + 1'b1;
  assign handshake    = evt_valid_o & evt_ready_i;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latch).
    state_n   = state_q;
    idx_n     = idx_q;
    settle_n  = settle_q;
    persist_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_n = '0;
        if (enable_i) state_n = S_SCAN;
      end
      S_SCAN: begin
        if (!enable_i) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (mismatch_i[idx_q]) begin
          state_n = S_REFRESH;
        end else begin
          idx_n = idx_inc;
        end
      end
      S_REFRESH: begin
        state_n  = S_SETTLE;
        settle_n = SET_W'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_n   = S_REPORT;
          persist_n = mismatch_i[idx_q];
        end else begin
          settle_n = settle_q - 1'b1;
        end
      end
      S_REPORT: begin
        persist_n = evt_persist_o;
        if (handshake) begin
          // Enable is only re-examined once the event has been delivered.
          if (enable_i) begin
            state_n = S_SCAN;
            idx_n   = idx_inc;
          end else begin
            state_n = S_IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign refresh_n = (state_n == S_REFRESH) ? (one_hot_base << idx_q) : '0;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      refresh_o     <= '0;
      evt_valid_o   <= 1'b0;
      evt_idx_o     <= '0;
      evt_persist_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      settle_q      <= settle_n;
      refresh_o     <= refresh_n;
      evt_valid_o   <= (state_n == S_REPORT);
      evt_idx_o     <= (state_n == S_REPORT) ? idx_q : '0;
      evt_persist_o <= (state_n == S_REPORT) ? persist_n : 1'b0;
      busy_o        <= (state_n != S_IDLE);
    end
  end

  // Clear has priority over a coincident refresh increment.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_count_o <= '0;
    end else if (clear_count_i) begin
      err_count_o <= '0;
    end else if ((state_q == S_REFRESH) && (err_count_o != '1)) begin
      err_count_o <= err_count_o + 1'b1;
    end
  end

endmodule
